// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder stage per clock.
// Operands are added LSB-first over WIDTH cycles with a registered carry.
// Handshake: start (accepted in IDLE or DONE), busy while processing bits,
// one-cycle done pulse when sum/cout update. sum/cout hold until the next
// completion.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input that
// selects a-b (two's complement); cout=1 then means no borrow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic             last;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] s_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // start is honoured in IDLE and DONE; ignored while bits are in flight
  assign accept = start && (state_q != ADD);
  assign last   = (state_q == ADD) && (cnt_q == CW'(WIDTH - 1));

  // single full-adder stage on the current LSBs
  assign fa_s    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign fa_c    = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
  assign s_shift = {fa_s, s_sr_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  // subtraction: a + ~b + 1, the injected 1 replacing cin
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last)  state_d = DONE;
      DONE:    state_d = start ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ADD);
    done = (state_q == DONE);
  end

  // datapath next values: load on accept, shift one bit per ADD cycle
  always_comb begin
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    s_sr_d = s_sr_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (accept) begin
      a_sr_d = a;
      b_sr_d = b_load;
      c_d    = c_load;
      s_sr_d = '0;
      cnt_d  = '0;
    end else if (state_q == ADD) begin
      a_sr_d = a_sr_q >> 1;
      b_sr_d = b_sr_q >> 1;
      s_sr_d = s_shift;
      c_d    = fa_c;
      cnt_d  = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        sum_d  = s_shift;
        cout_d = fa_c;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      s_sr_q <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      s_sr_q <= s_sr_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases from the
// test plan plus random operations against an arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // inputs change 1 time unit after the edge; outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: plain unsigned arithmetic
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    int unsigned r;
    if (sb) begin
      r = (int'(x) - int'(y)) & ((1 << W) - 1);
      return {(x >= y), r[W-1:0]};
    end
    r = int'(x) + int'(y) + int'(ci);
    return r[W:0];
  endfunction

  // drive a start for one cycle (edge k), then scramble the operands
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb);
    start = 1'b1; a = x; b = y; cin = ci; sub = sb;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // check busy over W cycles with held results, then the done cycle.
  // Returns positioned in the done cycle.
  task automatic run_check(input string tag, input logic [W:0] exp, input bit repulse);
    for (int i = 1; i <= W; i++) begin
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".nodone"}, done, 1'b0);
      if (i == 4) chk({tag, ".sumheld"}, {cout, sum}, {hold_cout, hold_sum});
      if (repulse && i == 3) begin
        start = 1'b1; a = 8'h55; b = 8'h55;
      end else start = 1'b0;
      step();
    end
    start = 1'b0;
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".busy_off"}, busy, 1'b0);
    chk({tag, ".sum"}, sum, exp[W-1:0]);
    chk({tag, ".cout"}, cout, exp[W]);
    hold_sum = exp[W-1:0];
    hold_cout = exp[W];
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic ci, input logic sb, input bit repulse);
    logic [W:0] e;
    e = model(x, y, ci, sb);
    issue(x, y, ci, sb);
    run_check(tag, e, repulse);
    step();
    chk({tag, ".idle_done"}, done, 1'b0);
    chk({tag, ".idle_sum"}, {cout, sum}, {hold_cout, hold_sum});
  endtask

  initial begin
    int seen_done;
    #12;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.sum", sum, 8'h00);
    chk("rst.cout", cout, 1'b0);
    rst_n = 1'b1;
    step();

    op("d0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    op("dff01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op("dffff", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    op("repulse", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);

    // back-to-back: second start accepted in the DONE cycle
    issue(8'h12, 8'h34, 1'b1, 1'b0);
    run_check("b2b1", model(8'h12, 8'h34, 1'b1, 1'b0), 1'b0);
    issue(8'hF0, 8'h20, 1'b0, 1'b0);
    run_check("b2b2", model(8'hF0, 8'h20, 1'b0, 1'b0), 1'b0);
    step();
    chk("b2b.idle", busy, 1'b0);

    // asynchronous reset in the middle of an addition
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 1'b0);
    chk("arst.done", done, 1'b0);
    chk("arst.sum", sum, 8'h00);
    chk("arst.cout", cout, 1'b0);
    hold_sum = '0; hold_cout = 1'b0;
    step();
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done) seen_done++;
      step();
    end
    chk("arst.no_done", seen_done, 0);
    op("post_rst", 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op("sub0507", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    op("sub0705", 8'h07, 8'h05, 1'b1, 1'b1, 1'b0);
`endif

    for (int n = 0; n < 20; n++) begin
      logic sb;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      op($sformatf("rnd%0d", n), W'($urandom), W'($urandom), 1'($urandom), sb, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: one full-adder stage per clock plus a registered carry, adding two WIDTH-bit operands LSB-first over WIDTH cycles.
- Consumes the single-bit sum/carry of the team's combinational full adder. Trades area for latency in datapaths where a WIDTH-bit ripple adder is too large.
- Start/busy/done handshake; result held stable until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled on the rising clk edge
- a  input  WIDTH  operand A; captured only on an accepted start
- b  input  WIDTH  operand B; captured only on an accepted start
- cin  input  1  carry-in; captured only on an accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum/cout are updated
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of the MSB

Behaviour:
- Reset is asynchronous and active-low. Assertion forces:
  - state=IDLE; busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry register and bit counter cleared
- Reset mid-operation aborts the addition; no done pulse is issued for it.
- States: IDLE, ADD, DONE.
  - IDLE: start=1 -> load a_sr<=a, b_sr<=b, c<=cin, s_sr<=0, cnt<=0; go to ADD.
  - ADD, each edge:
    - s = a_sr[0]^b_sr[0]^c
    - c <= a_sr[0]&b_sr[0] | c&(a_sr[0]^b_sr[0])
    - s_sr shifts right with s entering at the MSB; a_sr and b_sr shift right.
    - cnt <= cnt+1
    - On the edge processing bit WIDTH-1 (cnt==WIDTH-1): sum <= final shifted value, cout <= final carry; go to DONE.
  - DONE: lasts one cycle (done=1); then go to IDLE. A start seen in DONE is accepted exactly as in IDLE (back-to-back operation).
- start in ADD is ignored; the a/b/cin capture registers are untouched.
- Timing (start sampled at edge k):
  - busy=1 for cycles k+1 .. k+WIDTH, i.e. exactly WIDTH cycles.
  - done=1 for the cycle after edge k+WIDTH; sum/cout are valid from that cycle.
- sum/cout change only at the completing edge, never mid-operation; they hold their value through IDLE and later operations until the next completion.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the carry out of bit WIDTH-1. No internal width growth beyond WIDTH+1.
- Counter width is clog2(WIDTH) bits; cnt wraps to 0 on entering DONE.
- Inputs a/b/cin may change freely after the accepting edge.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1: b_sr loads ~b and c initialises to 1 (cin ignored), giving a-b in two's complement; cout=1 means no borrow (a>=b unsigned).
  - sub=0: behaviour identical to the base block.
- Undefined: no sub port; addition only.

Test Plan (WIDTH=8):
- Reset, then a=0x0F, b=0x01, cin=0, start for 1 cycle -> busy high 8 cycles; done pulse 1 cycle at edge k+9 sample; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start re-pulsed with a=0x55, b=0x55 at cycle k+3 of an operation on 0x0F+0x01 -> ignored; result 0x10 and done timing unchanged.
- Back-to-back: start held high through done -> second operation accepted in the DONE cycle; busy re-asserts next cycle; both results correct in sequence.
- rst_n pulled low at cycle k+4 of an addition -> busy, done, sum and cout all 0 immediately (asynchronous); no done pulse after release; next start works normally.
- SERIAL_ADDER_SUB_EN defined:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0.
  - a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
